// File: rtl/adder_serial.sv
// rtl/adder_serial.sv - digit-serial a + b + cin adder with valid/ready handshakes
// Defining ADDER_SERIAL_OVF_EN adds the registered signed-overflow output ovf.
module adder_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
`ifdef ADDER_SERIAL_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // Only the digits still to be completed need holding; the newest digit comes from the adder.
   localparam int SW = (N > 1) ? WIDTH - DIGIT : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [SW-1:0]    s_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] s_next;

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_digit
         $error("adder_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

   generate
      if (N == 1) begin : g_single
         assign s_next = digit_sum[DIGIT-1:0];
      end else begin : g_multi
         assign s_next = {digit_sum[DIGIT-1:0], s_sh};
      end
   endgenerate

`ifdef ADDER_SERIAL_OVF_EN
   logic a_msb;
   logic b_msb;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == BUSY && cnt == CW'(N - 1)) begin
         ovf <= (a_msb == b_msb) & (s_next[WIDTH-1] != a_msb);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         s_sh      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               carry <= digit_sum[DIGIT];
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               s_sh  <= s_next[WIDTH-1:WIDTH-SW];
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  s         <= s_next;
                  cout      <= digit_sum[DIGIT];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // in_ready stays low here so a consumed result never overlaps a new accept.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_serial.sv
// tb/tb_adder_serial.sv - directed and random checks of adder_serial (DIGIT=4 and DIGIT=32 builds)
module tb_adder_serial;

   localparam int WIDTH = 32;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, in_valid, cin, out_ready;
   logic [WIDTH-1:0] a, b;
   logic             in_ready, out_valid, cout, busy;
   logic [WIDTH-1:0] s;

   logic             in_valid2, cin2, out_ready2;
   logic [WIDTH-1:0] a2, b2;
   logic             in_ready2, out_valid2, cout2, busy2;
   logic [WIDTH-1:0] s2;
`ifdef ADDER_SERIAL_OVF_EN
   logic             ovf, ovf2;
`endif

   adder_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout),
`ifdef ADDER_SERIAL_OVF_EN
      .ovf(ovf),
`endif
      .busy(busy)
   );

   adder_serial #(.WIDTH(WIDTH), .DIGIT(WIDTH)) dut_wide (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
      .s(s2), .cout(cout2),
`ifdef ADDER_SERIAL_OVF_EN
      .ovf(ovf2),
`endif
      .busy(busy2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshake, wait for the result, optionally stall, then consume it.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input int stall, input logic [WIDTH:0] exp);
      int lat;
      check({tag, "_in_ready_before"}, 64'(in_ready), 64'd1);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'b1;
      lat = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(N + 1));
      repeat (stall) step();
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_sum"}, 64'({cout, s}), 64'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_released"}, 64'({in_ready, out_valid, busy}), 64'b100);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      bit               ok;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
      step(); step();
      rst = 1'b0;
      check("reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("reset_sum", 64'({cout, s}), 64'd0);
      check("reset_wide", 64'({in_ready2, out_valid2, busy2, cout2, s2}), {29'd0, 3'b100, 33'd0});

      // Full carry ripple through every digit.
      run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 33'h1_0000_0000);

      // Zero operands with per-cycle control checks.
      a = '0; b = '0; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      ok = 1'b1;
      for (int c = 1; c <= N; c++) begin
         if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
         step();
      end
      check("zero_busy_cycles", 64'(ok), 64'd1);
      check("zero_done_ctrl", 64'({in_ready, out_valid, busy}), 64'b011);
      check("zero_sum", 64'({cout, s}), 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("zero_in_ready_back", 64'(in_ready), 64'd1);

      // Backpressure for 20 cycles with an in_valid pulse that must be ignored.
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 100 && !out_valid; c++) step();
      ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin a = 32'hDEAD_BEEF; b = 32'h1; in_valid = 1'b1; end
         if (c == 6) in_valid = 1'b0;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, s} !== 33'h0_2345_6789) ok = 1'b0;
         step();
      end
      check("bp_stable", 64'(ok), 64'd1);
      check("bp_sum", 64'({cout, s}), 64'h0_2345_6789);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      check("bp_pulse_ignored", 64'({in_ready, busy}), 64'b10);

      // Reset in the fourth BUSY cycle, then rst together with a handshake.
      a = 32'hFFFF_0000; b = 32'h0000_FFFF; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      check("midrst_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
      check("midrst_sum", 64'({cout, s}), 64'd0);
      a = 32'd9; b = 32'd9; in_valid = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      step();
      check("rst_wins_handshake", 64'({in_ready, busy}), 64'b10);
      run_op("after_rst", 32'd5, 32'd7, 1'b1, 0, 33'd13);

      // DIGIT == WIDTH: one BUSY cycle.
      a2 = 32'h8000_0000; b2 = 32'h8000_0000; cin2 = 1'b0; in_valid2 = 1'b1;
      step();
      in_valid2 = 1'b0;
      check("wide_cycle1", 64'({in_ready2, out_valid2, busy2}), 64'b001);
      step();
      check("wide_cycle2_valid", 64'(out_valid2), 64'd1);
      check("wide_sum", 64'({cout2, s2}), 64'h1_0000_0000);
`ifdef ADDER_SERIAL_OVF_EN
      check("wide_ovf", 64'(ovf2), 64'd1);
`endif
      out_ready2 = 1'b1;
      step();
      out_ready2 = 1'b0;
      check("wide_released", 64'({in_ready2, out_valid2}), 64'b10);

`ifdef ADDER_SERIAL_OVF_EN
      run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 33'h0_8000_0000);
      check("ovf_pos_flag", 64'(ovf), 64'd1);
      run_op("ovf_none", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 33'h1_7FFF_FFFE);
      check("ovf_none_flag", 64'(ovf), 64'd0);
`endif

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         run_op("rand", ra, rb, rc, int'($urandom_range(0, 3)),
                {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adder_serial.md
Name: adder_serial

Overview:
- Digit-serial adder and the DUT-side counterpart of the adder testbench environment.
- Accepts one operand set {a, b, cin} through a valid/ready handshake and computes a + b + cin, DIGIT bits per clock, LSB digit first.
- Presents {cout, s} through a valid/ready output handshake.
- Provides a small-area alternative to the parallel adders and is checked against the same a + b + cin reference model.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- DIGIT, 4, bits processed per clock. WIDTH % DIGIT must be 0; otherwise $error at elaboration.
- Derived: N = WIDTH/DIGIT digit steps.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled only on the input handshake.
- b  input  WIDTH  operand B, sampled only on the input handshake.
- cin  input  1  carry in, sampled only on the input handshake.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum.
- cout  output  1  carry out.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - busy = 0
  - s = 0, cout = 0
  - internal shift registers, carry register and digit counter = 0
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b into operand shift registers and cin into the carry register; clear the counter; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: {c, d} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry, computed at DIGIT+1 bits.
  - carry <= c.
  - a_sh and b_sh shift right by DIGIT.
  - d shifts into s_sh from the MSB end, so after N steps s_sh holds the full sum.
  - counter increments.
  - When counter == N-1: load s <= final s_sh and cout <= final carry, then go to DONE.
- DONE:
  - out_valid = 1; s and cout are stable.
  - On out_ready: go to IDLE.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Latency: let cycle 0 be the input handshake cycle. BUSY occupies cycles 1..N. out_valid is high from cycle N+1.
- Throughput: at most one operation per N+2 cycles (out_ready held high).
- Backpressure: out_ready low holds DONE indefinitely; s, cout and out_valid stay unchanged.
- in_valid and input data changes while in BUSY or DONE are ignored; no queuing.
- s and cout keep the last result after the output handshake. They are meaningful only while out_valid = 1.
- Width rule: the final carry out of the top digit is cout. No truncation of intermediate carries.
- DIGIT == WIDTH gives N = 1: one BUSY cycle, then DONE.
- Reset mid-operation (BUSY or DONE): the operation is discarded; all outputs return to reset values on the next edge.
- Simultaneous rst and a handshake: rst wins and nothing is latched.

Optional Feature:
- Macro: ADDER_SERIAL_OVF_EN.
- When defined: adds output port ovf (output, 1 bit), the two's-complement signed overflow flag.
  - ovf = (a[WIDTH-1] == b[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]), using the latched operand MSBs.
  - Registered and updated together with s and cout.
  - Reset value 0.
  - Valid only while out_valid = 1.
- When not defined: the port does not exist and the MSB-capture register is not built.

Test Plan:
- WIDTH=32, DIGIT=4: a=0xFFFFFFFF, b=0x00000000, cin=1 -> out_valid at cycle 9 after handshake; s=0x00000000, cout=1.
- a=0, b=0, cin=0 -> s=0, cout=0. Also check in_ready=0 and busy=1 during cycles 1..9, and in_ready returns to 1 one cycle after out_ready.
- Backpressure: a=0x12345678, b=0x11111111, cin=0, out_ready held low for 20 cycles -> s=0x23456789 and out_valid held stable throughout. A new in_valid pulse during this time is ignored.
- Reset mid-op: assert rst at cycle 4 of BUSY -> next cycle state IDLE, in_ready=1, out_valid=0, s=0, cout=0. A following a=5, b=7, cin=1 yields s=13.
- DIGIT=32 build: a=0x80000000, b=0x80000000, cin=0 -> out_valid at cycle 2; s=0, cout=1. With ADDER_SERIAL_OVF_EN: ovf=1.
- Random: 1000 iterations of $random a, b, cin with random out_ready stalls -> every result matches a + b + cin; zero mismatches reported.
